// File: rtl/touch_sequencer_if.sv
// -----------------------------------------------------------------------------
// touch_sequencer_if
// Byte-level handshake between the touch sequencer and an I2C byte engine.
//   req_out   : one-cycle pulse starting one byte transaction (sequencer -> engine)
//   addr_out  : {7-bit device address, R/W}, R/W=1 for read
//   wdata_out : byte to write
//   last_out  : engine issues STOP after this byte
//   done_in   : one-cycle pulse when the byte transaction completes (engine -> sequencer)
//   rdata_in  : read byte, valid with done_in
//   nack_in   : NACK flag, valid with done_in
// -----------------------------------------------------------------------------
interface touch_sequencer_if;
  logic       req_out;
  logic [7:0] addr_out;
  logic [7:0] wdata_out;
  logic       last_out;
  logic       done_in;
  logic [7:0] rdata_in;
  logic       nack_in;

  modport master (
    output req_out, addr_out, wdata_out, last_out,
    input  done_in, rdata_in, nack_in
  );

  modport slave (
    input  req_out, addr_out, wdata_out, last_out,
    output done_in, rdata_in, nack_in
  );
endinterface

// File: rtl/touch_sequencer.sv
// -----------------------------------------------------------------------------
// touch_sequencer
// Reads one touch sample from an I2C touch controller whenever its interrupt
// line is low: writes register pointer 0x02, reads STAT, XH, XL, YH, YL, then
// publishes clamped coordinates when STAT reports one or two touches. Sample
// attempts are separated by at least GAP_CYC idle cycles.
// Ports:
//   clk_in    : system clock
//   rst_in    : asynchronous active-low reset
//   irq_in    : touch interrupt, active-low, asynchronous to clk_in
//   bus       : byte-engine handshake (master side)
//   valid_out : one-cycle pulse when x_out/y_out/event_out update
//   x_out     : x coordinate, clamped to NUM_COLS-1
//   y_out     : y coordinate, clamped to NUM_ROWS-1
//   event_out : touch event code (XH[7:6])
//   err_out   : one-cycle pulse on NACK or byte timeout
//   busy_out  : high whenever the sequencer is not idle
// -----------------------------------------------------------------------------
module touch_sequencer #(
  parameter logic [6:0] DEV_ADDR    = 7'h38,
  parameter int         NUM_COLS    = 240,
  parameter int         NUM_ROWS    = 320,
  parameter int         TIMEOUT_CYC = 1_000_000,
  parameter int         GAP_CYC     = 100_000
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      irq_in,
  touch_sequencer_if.master         bus,
  output logic                      valid_out,
  output logic [11:0]               x_out,
  output logic [11:0]               y_out,
  output logic [1:0]                event_out,
  output logic                      err_out,
  output logic                      busy_out
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int GW = $clog2(GAP_CYC + 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYC - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);
  localparam logic [11:0]   X_MAX    = 12'(NUM_COLS - 1);
  localparam logic [11:0]   Y_MAX    = 12'(NUM_ROWS - 1);

  typedef enum logic [2:0] {S_IDLE, S_PTR, S_RD, S_EVAL, S_HOLD} state_t;

  function automatic logic [11:0] clamp_coord(input logic [11:0] v, input logic [11:0] lim);
    return (v > lim) ? lim : v;
  endfunction

  state_t        state_q, state_nxt;
  logic          irq_sync_p0, irq_sync_p1;
  logic          pending_q, pending_nxt;
  logic [2:0]    byte_cnt_q, byte_cnt_nxt;
  logic [TW-1:0] wait_cnt_q, wait_cnt_nxt;
  logic [GW-1:0] gap_cnt_q, gap_cnt_nxt;
  logic [3:0]    stat_q, stat_nxt;
  logic [1:0]    xev_q, xev_nxt;
  logic [3:0]    xh_q, xh_nxt;
  logic [7:0]    xl_q, xl_nxt;
  logic [3:0]    yh_q, yh_nxt;
  logic          req_q, req_nxt;
  logic [7:0]    addr_q, addr_nxt;
  logic [7:0]    wdata_q, wdata_nxt;
  logic          last_q, last_nxt;
  logic          valid_q, valid_nxt;
  logic          err_q, err_nxt;
  logic [11:0]   x_q, x_nxt;
  logic [11:0]   y_q, y_nxt;
  logic [1:0]    ev_q, ev_nxt;

  // Stage p0/p1: two-flop synchronizer on the interrupt line
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      irq_sync_p0 <= 1'b1;
      irq_sync_p1 <= 1'b1;
    end else begin
      irq_sync_p0 <= irq_in;
      irq_sync_p1 <= irq_sync_p0;
    end
  end

  // Sequencer state and registered outputs
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= S_IDLE;
      pending_q  <= 1'b0;
      byte_cnt_q <= '0;
      wait_cnt_q <= '0;
      gap_cnt_q  <= '0;
      stat_q     <= '0;
      xev_q      <= '0;
      xh_q       <= '0;
      xl_q       <= '0;
      yh_q       <= '0;
      req_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      last_q     <= 1'b0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      ev_q       <= '0;
    end else begin
      state_q    <= state_nxt;
      pending_q  <= pending_nxt;
      byte_cnt_q <= byte_cnt_nxt;
      wait_cnt_q <= wait_cnt_nxt;
      gap_cnt_q  <= gap_cnt_nxt;
      stat_q     <= stat_nxt;
      xev_q      <= xev_nxt;
      xh_q       <= xh_nxt;
      xl_q       <= xl_nxt;
      yh_q       <= yh_nxt;
      req_q      <= req_nxt;
      addr_q     <= addr_nxt;
      wdata_q    <= wdata_nxt;
      last_q     <= last_nxt;
      valid_q    <= valid_nxt;
      err_q      <= err_nxt;
      x_q        <= x_nxt;
      y_q        <= y_nxt;
      ev_q       <= ev_nxt;
    end
  end

  // Next-state logic. A byte is "pending" from its req_out until done_in or
  // timeout; the outputs to the engine are only rewritten when nothing is
  // pending, which keeps them stable across the transaction. The final read's
  // byte is evaluated straight from rdata_in so valid_out lands one cycle
  // after the last done_in, during the EVAL cycle.
  always_comb begin
    state_nxt    = state_q;
    pending_nxt  = pending_q;
    byte_cnt_nxt = byte_cnt_q;
    wait_cnt_nxt = wait_cnt_q;
    gap_cnt_nxt  = gap_cnt_q;
    stat_nxt     = stat_q;
    xev_nxt      = xev_q;
    xh_nxt       = xh_q;
    xl_nxt       = xl_q;
    yh_nxt       = yh_q;
    req_nxt      = 1'b0;
    addr_nxt     = addr_q;
    wdata_nxt    = wdata_q;
    last_nxt     = last_q;
    valid_nxt    = 1'b0;
    err_nxt      = 1'b0;
    x_nxt        = x_q;
    y_nxt        = y_q;
    ev_nxt       = ev_q;

    unique case (state_q)
      S_IDLE: begin
        if (!irq_sync_p1) state_nxt = S_PTR;
      end

      S_PTR, S_RD: begin
        if (!pending_q) begin
          req_nxt      = 1'b1;
          pending_nxt  = 1'b1;
          wait_cnt_nxt = '0;
          if (state_q == S_PTR) begin
            addr_nxt  = {DEV_ADDR, 1'b0};
            wdata_nxt = 8'h02;
            last_nxt  = 1'b1;
          end else begin
            addr_nxt  = {DEV_ADDR, 1'b1};
            wdata_nxt = 8'h00;
            last_nxt  = (byte_cnt_q == 3'd4);
          end
        end else if (bus.done_in) begin
          // done_in wins over a coincident timeout expiry
          pending_nxt = 1'b0;
          if (bus.nack_in) begin
            err_nxt     = 1'b1;
            state_nxt   = S_HOLD;
            gap_cnt_nxt = '0;
          end else if (state_q == S_PTR) begin
            state_nxt    = S_RD;
            byte_cnt_nxt = '0;
          end else begin
            case (byte_cnt_q)
              3'd0: stat_nxt = bus.rdata_in[3:0];
              3'd1: begin
                xev_nxt = bus.rdata_in[7:6];
                xh_nxt  = bus.rdata_in[3:0];
              end
              3'd2: xl_nxt = bus.rdata_in;
              3'd3: yh_nxt = bus.rdata_in[3:0];
              default: ;
            endcase
            if (byte_cnt_q == 3'd4) begin
              state_nxt = S_EVAL;
              if (stat_q == 4'd1 || stat_q == 4'd2) begin
                valid_nxt = 1'b1;
                x_nxt     = clamp_coord({xh_q, xl_q}, X_MAX);
                y_nxt     = clamp_coord({yh_q, bus.rdata_in}, Y_MAX);
                ev_nxt    = xev_q;
              end
            end else begin
              byte_cnt_nxt = byte_cnt_q + 3'd1;
            end
          end
        end else if (wait_cnt_q == TO_LAST) begin
          err_nxt     = 1'b1;
          pending_nxt = 1'b0;
          state_nxt   = S_HOLD;
          gap_cnt_nxt = '0;
        end else begin
          wait_cnt_nxt = wait_cnt_q + TW'(1);
        end
      end

      S_EVAL: begin
        state_nxt   = S_HOLD;
        gap_cnt_nxt = '0;
      end

      S_HOLD: begin
        if (gap_cnt_q == GAP_LAST) state_nxt = S_IDLE;
        else                       gap_cnt_nxt = gap_cnt_q + GW'(1);
      end

      default: state_nxt = S_IDLE;
    endcase
  end

  assign bus.req_out   = req_q;
  assign bus.addr_out  = addr_q;
  assign bus.wdata_out = wdata_q;
  assign bus.last_out  = last_q;
  assign valid_out     = valid_q;
  assign err_out       = err_q;
  assign x_out         = x_q;
  assign y_out         = y_q;
  assign event_out     = ev_q;
  assign busy_out      = (state_q != S_IDLE);

endmodule

// File: tb/tb_touch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_touch_sequencer
// Directed bench for touch_sequencer with a behavioural I2C byte engine that
// answers each req_out after a programmable delay.
// -----------------------------------------------------------------------------
module tb_touch_sequencer;
  localparam int TO  = 40;
  localparam int GAP = 30;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        irq_in = 1'b1;
  logic        valid_out, err_out, busy_out;
  logic [11:0] x_out, y_out;
  logic [1:0]  event_out;

  touch_sequencer_if bus();

  touch_sequencer #(
    .DEV_ADDR(7'h38), .NUM_COLS(240), .NUM_ROWS(320),
    .TIMEOUT_CYC(TO), .GAP_CYC(GAP)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .irq_in(irq_in), .bus(bus),
    .valid_out(valid_out), .x_out(x_out), .y_out(y_out),
    .event_out(event_out), .err_out(err_out), .busy_out(busy_out)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  // Engine controls (written only by the stimulus process)
  logic [7:0] rd_bytes [5];
  int         eng_dly  = 2;
  bit         eng_mute = 1'b0;
  bit         nack_ptr = 1'b0;

  // Engine state and monitor log (written only by the engine process)
  int         eng_cnt = 0;
  int         rd_idx = 0;
  logic [7:0] cur_byte, cur_addr, cur_wdata;
  logic       cur_last, cur_nack;
  int         req_cnt = 0;
  int         req_cyc [256];
  logic [7:0] req_addr [256];
  logic       req_last [256];
  int         done_cyc = 0, valid_cnt = 0, valid_cyc = 0;
  int         err_cnt = 0, err_cyc = 0, idle_cyc = 0;
  int         stab_bad = 0, overlap_bad = 0;
  logic       busy_prev = 1'b0;

  always @(negedge clk_in) begin
    bus.done_in = 1'b0;
    bus.nack_in = 1'b0;
    if (eng_cnt > 0) begin
      if (rst_in && busy_out &&
          (bus.addr_out != cur_addr || bus.wdata_out != cur_wdata || bus.last_out != cur_last))
        stab_bad++;
      eng_cnt--;
      if (eng_cnt == 0) begin
        bus.done_in  = 1'b1;
        bus.rdata_in = cur_byte;
        bus.nack_in  = cur_nack;
        done_cyc     = cyc;
      end
    end
    if (bus.req_out) begin
      if (eng_cnt > 0) overlap_bad++;
      if (req_cnt < 256) begin
        req_cyc[req_cnt]  = cyc;
        req_addr[req_cnt] = bus.addr_out;
        req_last[req_cnt] = bus.last_out;
      end
      req_cnt++;
      cur_addr  = bus.addr_out;
      cur_wdata = bus.wdata_out;
      cur_last  = bus.last_out;
      cur_nack  = nack_ptr && !bus.addr_out[0];
      if (!bus.addr_out[0]) rd_idx = 0;
      cur_byte  = bus.addr_out[0] ? rd_bytes[rd_idx] : 8'h00;
      if (bus.addr_out[0] && rd_idx < 4) rd_idx++;
      if (!eng_mute) eng_cnt = eng_dly;
    end
    if (valid_out) begin valid_cnt++; valid_cyc = cyc; end
    if (err_out)   begin err_cnt++;   err_cyc   = cyc; end
    if (busy_prev && !busy_out) idle_cyc = cyc;
    busy_prev = busy_out;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic wait_req(input int target, input int bound, input string name);
    int n = 0;
    while (req_cnt < target && n < bound) begin
      @(negedge clk_in); #1;
      n++;
    end
    if (req_cnt < target) begin
      checks++; errors++;
      $display("FAIL %s: req_out count %0d, expected %0d within %0d cycles", name, req_cnt, target, bound);
    end
  endtask

  task automatic wait_idle(input int bound, input string name);
    int n = 0;
    while (busy_out && n < bound) begin
      @(negedge clk_in); #1;
      n++;
    end
    if (busy_out) begin
      checks++; errors++;
      $display("FAIL %s: busy_out still 1 after %0d cycles, expected 0", name, bound);
    end
  endtask

  task automatic set_bytes(input logic [39:0] b);
    for (int i = 0; i < 5; i++) rd_bytes[i] = b[39 - 8*i -: 8];
  endtask

  typedef struct {
    logic [39:0] bytes;   // STAT, XH, XL, YH, YL
    int          dly;
    logic        exp_valid;
    logic [11:0] exp_x;
    logic [11:0] exp_y;
    logic [1:0]  exp_ev;
  } vec_t;

  vec_t vecs [7];

  // One full sample: irq pulled low, released after the first request
  // (the transaction must still run to completion), then idle again.
  task automatic run_txn(input vec_t v, input string tag);
    int  base = req_cnt;
    int  v0   = valid_cnt;
    int  e0   = err_cnt;
    bit  ok   = 1'b1;
    set_bytes(v.bytes);
    eng_dly = v.dly;
    irq_in  = 1'b0;
    wait_req(base + 1, 20, {tag, "_start"});
    irq_in  = 1'b1;
    wait_idle(600, {tag, "_idle"});
    chk({tag, "_reqs"},  req_cnt - base, 6);
    chk({tag, "_valid"}, valid_cnt - v0, v.exp_valid ? 1 : 0);
    chk({tag, "_err"},   err_cnt - e0, 0);
    chk({tag, "_x"},     x_out, v.exp_x);
    chk({tag, "_y"},     y_out, v.exp_y);
    chk({tag, "_ev"},    event_out, v.exp_ev);
    if (v.exp_valid) chk({tag, "_lat"}, valid_cyc - done_cyc, 1);
    chk({tag, "_hold"},  idle_cyc - done_cyc, GAP + 2);
    for (int i = 0; i < 6; i++) begin
      if (req_addr[base + i] != ((i == 0) ? 8'h70 : 8'h71)) ok = 1'b0;
      if (req_last[base + i] != (i == 0 || i == 5)) ok = 1'b0;
    end
    chk({tag, "_seq"}, ok, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, v0, e0;
    vecs[0] = '{40'h01_00_64_00_C8, 2,      1'b1, 12'd100, 12'd200, 2'd0};
    vecs[1] = '{40'h01_4F_FF_0F_FF, 3,      1'b1, 12'd239, 12'd319, 2'd1};
    vecs[2] = '{40'h00_4F_10_00_20, 2,      1'b0, 12'd239, 12'd319, 2'd1};
    vecs[3] = '{40'h02_C0_10_01_00, 1,      1'b1, 12'd16,  12'd256, 2'd3};
    vecs[4] = '{40'h03_00_01_00_01, 2,      1'b0, 12'd16,  12'd256, 2'd3};
    vecs[5] = '{40'h12_80_EF_01_3F, 2,      1'b1, 12'd239, 12'd319, 2'd2};
    vecs[6] = '{40'h01_00_F0_01_40, TO - 1, 1'b1, 12'd239, 12'd319, 2'd0};

    // Reset state
    repeat (3) @(negedge clk_in);
    #1;
    chk("reset_outs", {valid_out, err_out, busy_out, bus.req_out, bus.addr_out,
                       bus.wdata_out, bus.last_out, x_out, y_out, event_out}, 0);
    rst_in = 1'b1;
    repeat (5) @(negedge clk_in);
    #1;
    chk("idle_no_req", req_cnt, 0);

    for (int i = 0; i < 7; i++) run_txn(vecs[i], $sformatf("v%0d", i));

    // NACK on the pointer write: no reads, error pulse, hold, idle
    base = req_cnt; v0 = valid_cnt; e0 = err_cnt;
    set_bytes(40'h01_00_64_00_C8);
    eng_dly = 2; nack_ptr = 1'b1;
    irq_in = 1'b0;
    wait_req(base + 1, 20, "nack_start");
    irq_in = 1'b1;
    wait_idle(200, "nack_idle");
    nack_ptr = 1'b0;
    chk("nack_reqs",  req_cnt - base, 1);
    chk("nack_err",   err_cnt - e0, 1);
    chk("nack_valid", valid_cnt - v0, 0);
    chk("nack_lat",   err_cyc - done_cyc, 1);
    chk("nack_hold",  idle_cyc - done_cyc, GAP + 1);

    // Engine never answers: timeout
    base = req_cnt; v0 = valid_cnt; e0 = err_cnt;
    eng_mute = 1'b1;
    irq_in = 1'b0;
    wait_req(base + 1, 20, "to_start");
    irq_in = 1'b1;
    wait_idle(TO + GAP + 50, "to_idle");
    eng_mute = 1'b0;
    chk("to_reqs", req_cnt - base, 1);
    chk("to_err",  err_cnt - e0, 1);
    chk("to_lat",  err_cyc - req_cyc[base], TO);
    chk("to_hold", idle_cyc - err_cyc, GAP);
    chk("to_valid", valid_cnt - v0, 0);

    // irq held low: repeated bursts, then reset during the 3rd read of burst 3
    base = req_cnt;
    set_bytes(40'h01_00_64_00_C8);
    eng_dly = 2;
    irq_in = 1'b0;
    wait_req(base + 16, 3000, "held_bursts");
    chk("gap_b1_b2", (req_cyc[base + 6] - req_cyc[base + 5]) >= GAP, 1);
    chk("gap_b2_b3", (req_cyc[base + 12] - req_cyc[base + 11]) >= GAP, 1);
    chk("b3_rd3_addr", req_addr[base + 15], 8'h71);
    v0 = valid_cnt; e0 = err_cnt;
    rst_in = 1'b0;
    irq_in = 1'b1;
    #1;
    chk("midrst_outs", {valid_out, err_out, busy_out, bus.req_out, bus.addr_out,
                        bus.wdata_out, bus.last_out, x_out, y_out, event_out}, 0);
    @(negedge clk_in); #1;
    rst_in = 1'b1;
    base = req_cnt;
    repeat (3 * GAP) @(negedge clk_in);
    #1;
    chk("post_rst_reqs",  req_cnt - base, 0);
    chk("post_rst_err",   err_cnt - e0, 0);
    chk("post_rst_valid", valid_cnt - v0, 0);
    chk("post_rst_busy",  busy_out, 0);

    // Recovery once irq is seen again
    run_txn(vecs[0], "recover");

    chk("req_overlap", overlap_bad, 0);
    chk("bus_stable",  stab_bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/touch_sequencer.md
TOUCH_SEQUENCER -- requirements
Module: touch_sequencer

Interface
REQ-001 Parameter DEV_ADDR, 7'h38, 7-bit I2C address of the touch controller.
REQ-002 Parameter NUM_COLS, 240, x clamp limit; NUM_ROWS, 320, y clamp limit.
REQ-003 Parameter TIMEOUT_CYC, 1_000_000, maximum cycles to wait for one byte transaction.
REQ-004 Parameter GAP_CYC, 100_000, minimum idle cycles between sample attempts.
REQ-005 clk_in  in  1  system clock; the only clock.
REQ-006 rst_in  in  1  reset, asynchronous, active-low.
REQ-007 irq_in  in  1  touch interrupt, active-low, asynchronous to clk_in.
REQ-008 req_out  out  1  one-cycle pulse that starts one byte transaction on the I2C byte engine.
REQ-009 addr_out  out  8  {DEV_ADDR, R/W}; R/W is 0 for write and 1 for read.
REQ-010 wdata_out  out  8  write byte.
REQ-011 last_out  out  1  engine issues STOP after this byte.
REQ-012 done_in  in  1  one-cycle pulse when the byte transaction completes.
REQ-013 rdata_in  in  8  read byte, valid with done_in.
REQ-014 nack_in  in  1  NACK flag, valid with done_in.
REQ-015 valid_out  out  1  one-cycle pulse when x_out, y_out and event_out are updated.
REQ-016 x_out, y_out  out  12 each  touch coordinates; event_out  out  2  touch event code.
REQ-017 err_out  out  1  one-cycle pulse on NACK or timeout.
REQ-018 busy_out  out  1  high in every state other than IDLE.

Function
REQ-019 irq_in shall pass through a 2-flop synchronizer before use; a touch request is the synchronized level being low.
REQ-020 The FSM shall have the states IDLE, PTR, RD, EVAL, HOLD.
REQ-021 IDLE->PTR shall occur when the synchronized irq is low.
REQ-022 PTR shall issue one write byte: addr_out={DEV_ADDR,0}, wdata_out=8'h02, last_out=1.
REQ-023 RD shall issue 5 read bytes with addr_out={DEV_ADDR,1}, stored in order as STAT, XH, XL, YH, YL; last_out=1 only on the 5th byte.
REQ-024 req_out shall assert exactly one cycle per byte; the next req_out shall not be issued before done_in for the previous byte.
REQ-025 addr_out, wdata_out and last_out shall remain stable from req_out until done_in.
REQ-026 A per-byte wait counter shall clear at req_out; when it reaches TIMEOUT_CYC with no done_in, the block shall pulse err_out and enter HOLD.
REQ-027 done_in with nack_in=1 shall pulse err_out, discard the remaining bytes and enter HOLD.
REQ-028 EVAL shall take one cycle: when STAT[3:0] is 1 or 2, the block shall update the outputs and pulse valid_out; otherwise it shall update nothing; EVAL then enters HOLD.
REQ-029 x = {XH[3:0],XL}; y = {YH[3:0],YL}; event_out = XH[7:6].
REQ-030 x shall be clamped to NUM_COLS-1 and y to NUM_ROWS-1 (unsigned compare).
REQ-031 HOLD shall count GAP_CYC cycles and then enter IDLE; a held-low irq therefore produces repeated samples spaced at least GAP_CYC apart.
REQ-032 irq rising (release) mid-transaction shall not abort the transaction; the sequence completes normally.
REQ-033 done_in received outside PTR or RD shall be ignored.
REQ-034 When done_in and the timeout expiry occur in the same cycle, done_in shall take priority.
REQ-035 Latency from the final done_in to valid_out shall be exactly 1 cycle.

Reset
REQ-036 rst_in low shall immediately force: state IDLE, all counters 0, synchronizer 1s, req_out=0, valid_out=0, err_out=0, busy_out=0, x_out=0, y_out=0, event_out=0, addr_out=0, wdata_out=0, last_out=0.
REQ-037 Reset asserted mid-transaction shall abandon the transaction with no err_out; after release the block waits in IDLE for irq.

Verification
REQ-038 irq low, engine model returns 01,00,64,00,C8 -> 1 write plus 5 reads, then valid_out with x=100, y=200, event=0.
REQ-039 Reads return 01,4F,FF,0F,FF -> x=239, y=319, event=1 (clamped).
REQ-040 STAT=00 -> no valid_out, no err_out, HOLD for GAP_CYC cycles, then IDLE.
REQ-041 NACK on the PTR write -> err_out pulse, no read requests issued, HOLD.
REQ-042 Engine never returns done_in -> err_out exactly TIMEOUT_CYC cycles after req_out.
REQ-043 irq held low -> successive req_out bursts spaced at least GAP_CYC cycles apart; rst_in pulsed during the 3rd read -> all outputs 0 and no further req_out until irq is seen again.
